ssd_bin2bcd: RTL and testbench

Sequential binary-to-BCD converter that drives the four-digit seven-segment display controller. It converts a 14-bit unsigned value to four BCD digits using iterative shift-and-add-3 (double dabble), one bit per clock. It also generates the per-digit enable mask with optional leading-zero blanking. Its digit0..digit3 and mode outputs connect directly to the display controller's inputs of the same name; digit0 is the least significant (rightmost) digit.

---
 rtl/ssd_bin2bcd.sv | 140 ++++++++++++++
 tb/tb_ssd_bin2bcd.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/ssd_bin2bcd.sv
// ssd_bin2bcd: sequential 14-bit binary to 4-digit BCD converter (double dabble,
// one bit per clock) feeding the seven-segment display controller. Also produces
// the per-digit enable mask, optionally blanking leading zeros.
module ssd_bin2bcd #(
    parameter int BLANK_LZ = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [13:0] bin,
    output logic        busy,
    output logic        done,
    output logic        ovf,
    output logic [3:0]  digit0,
    output logic [3:0]  digit1,
    output logic [3:0]  digit2,
    output logic [3:0]  digit3,
    output logic [3:0]  mode
);

    localparam logic [1:0]  S_IDLE   = 2'd0;
    localparam logic [1:0]  S_CONV   = 2'd1;
    localparam logic [1:0]  S_LOAD   = 2'd2;
    localparam logic [3:0]  LAST_STEP = 4'd13;
    localparam logic [13:0] MAX_VAL  = 14'd9999;
    localparam logic [3:0]  MODE_RST = (BLANK_LZ != 0) ? 4'b0001 : 4'b1111;

    // Values above the four-digit range are clamped to 9999.
    function automatic logic [13:0] sat_operand(input logic [13:0] v);
        return (v > MAX_VAL) ? MAX_VAL : v;
    endfunction

    // Double-dabble correction: every nibble >= 5 gets +3, no inter-nibble carry.
    function automatic logic [15:0] add3(input logic [15:0] a);
        logic [15:0] r;
        r = a;
        for (int k = 0; k < 4; k++) begin
            if (a[4*k +: 4] >= 4'd5) r[4*k +: 4] = a[4*k +: 4] + 4'd3;
        end
        return r;
    endfunction

    // Digit k is lit when it or any more significant digit is nonzero; digit 0 always lit.
    function automatic logic [3:0] mode_of(input logic [15:0] a);
        logic [3:0] m;
        if (BLANK_LZ == 0) begin
            m = 4'b1111;
        end else begin
            m[3] = (a[15:12] != 4'd0);
            m[2] = m[3] | (a[11:8] != 4'd0);
            m[1] = m[2] | (a[7:4] != 4'd0);
            m[0] = 1'b1;
        end
        return m;
    endfunction

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] acc_q, acc_d;
    logic [13:0] opr_q, opr_d;
    logic        povf_q, povf_d;
    logic [15:0] dig_q, dig_d;
    logic [3:0]  mode_q, mode_d;
    logic        ovf_q, ovf_d;
    logic        done_q, done_d;
    logic [29:0] shift_src;

    // Next-state logic: accept in IDLE, shift one bit per CONV step, publish in LOAD.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opr_d     = opr_q;
        povf_d    = povf_q;
        dig_d     = dig_q;
        mode_d    = mode_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        shift_src = {add3(acc_q), opr_q};
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    opr_d   = sat_operand(bin);
                    povf_d  = (bin > MAX_VAL);
                    acc_d   = 16'd0;
                    cnt_d   = 4'd0;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                {acc_d, opr_d} = {shift_src[28:0], 1'b0};
                cnt_d          = cnt_q + 4'd1;
                if (cnt_q == LAST_STEP) state_d = S_LOAD;
            end
            S_LOAD: begin
                dig_d   = acc_q;
                mode_d  = mode_of(acc_q);
                ovf_d   = povf_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; synchronous active-low reset clears everything.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            acc_q   <= 16'd0;
            opr_q   <= 14'd0;
            povf_q  <= 1'b0;
            dig_q   <= 16'd0;
            mode_q  <= MODE_RST;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opr_q   <= opr_d;
            povf_q  <= povf_d;
            dig_q   <= dig_d;
            mode_q  <= mode_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = done_q;
    assign ovf    = ovf_q;
    assign mode   = mode_q;
    assign digit0 = dig_q[3:0];
    assign digit1 = dig_q[7:4];
    assign digit2 = dig_q[11:8];
    assign digit3 = dig_q[15:12];

endmodule

// File: tb/tb_ssd_bin2bcd.sv
// Testbench for ssd_bin2bcd: table of directed conversions plus hand-written
// sequences for start-while-busy, chained start in the done cycle and mid-run reset.
module tb_ssd_bin2bcd;

    logic        clk;
    logic        rst;
    logic        start;
    logic [13:0] bin;
    logic        busy, done, ovf;
    logic [3:0]  digit0, digit1, digit2, digit3, mode;
    logic        busy1, done1, ovf1;
    logic [3:0]  e0, e1, e2, e3, mode1;
    logic [15:0] dig, dig1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] prev_bcd;
    logic [3:0]  prev_mode;
    logic        prev_ovf;

    typedef struct {
        logic [13:0] b;
        logic [15:0] bcd;
        logic [3:0]  m;
        logic        o;
    } vec_t;

    vec_t tbl[10];

    ssd_bin2bcd #(.BLANK_LZ(1)) u_dut (
        .clk(clk), .rst(rst), .start(start), .bin(bin),
        .busy(busy), .done(done), .ovf(ovf),
        .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
        .mode(mode)
    );

    ssd_bin2bcd #(.BLANK_LZ(0)) u_dut_nb (
        .clk(clk), .rst(rst), .start(start), .bin(bin),
        .busy(busy1), .done(done1), .ovf(ovf1),
        .digit0(e0), .digit1(e1), .digit2(e2), .digit3(e3),
        .mode(mode1)
    );

    assign dig  = {digit3, digit2, digit1, digit0};
    assign dig1 = {e3, e2, e1, e0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called at a negedge: present start/bin so the next posedge (E0) accepts them.
    task automatic kick(input logic [13:0] b);
        start = 1'b1;
        bin   = b;
        @(posedge clk);
    endtask

    // Called right after E0. Watches 16 negedges (after E0..E15).
    task automatic expect_run(input logic [15:0] ebcd, input logic [3:0] em, input logic eovf,
                              input bit inject, input bit chain, input logic [13:0] chain_bin);
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            if (n == 0) start = 1'b0;
            if (inject && n == 4) begin
                start = 1'b1;
                bin   = 14'd5678;
            end
            if (inject && n == 5) start = 1'b0;
            if (n < 15) begin
                chk($sformatf("busy_phase_n%0d", n),
                    {7'd0, busy, done, ovf, mode, dig, busy1, done1, mode1},
                    {7'd0, 1'b1, 1'b0, prev_ovf, prev_mode, prev_bcd, 1'b1, 1'b0, 4'b1111});
            end else begin
                chk("done_cycle", {busy, done, busy1, done1}, 4'b0101);
                chk("result", {ovf, mode, dig}, {eovf, em, ebcd});
                chk("result_noblank", {ovf1, mode1, dig1}, {eovf, 4'b1111, ebcd});
                prev_bcd  = ebcd;
                prev_mode = em;
                prev_ovf  = eovf;
                if (chain) begin
                    start = 1'b1;
                    bin   = chain_bin;
                end
            end
        end
        if (!chain) begin
            @(negedge clk);
            chk("done_single_pulse", {busy, done}, 2'b00);
        end
    endtask

    initial begin
        tbl[0] = '{14'd1234,  16'h1234, 4'b1111, 1'b0};
        tbl[1] = '{14'd0,     16'h0000, 4'b0001, 1'b0};
        tbl[2] = '{14'd7,     16'h0007, 4'b0001, 1'b0};
        tbl[3] = '{14'd42,    16'h0042, 4'b0011, 1'b0};
        tbl[4] = '{14'd9999,  16'h9999, 4'b1111, 1'b0};
        tbl[5] = '{14'd10000, 16'h9999, 4'b1111, 1'b1};
        tbl[6] = '{14'd16383, 16'h9999, 4'b1111, 1'b1};
        tbl[7] = '{14'd5,     16'h0005, 4'b0001, 1'b0};
        tbl[8] = '{14'd1000,  16'h1000, 4'b1111, 1'b0};
        tbl[9] = '{14'd305,   16'h0305, 4'b0111, 1'b0};

        rst   = 1'b0;
        start = 1'b0;
        bin   = 14'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        chk("reset_state", {busy, done, ovf, mode, dig}, {1'b0, 1'b0, 1'b0, 4'b0001, 16'h0000});
        chk("reset_state_noblank", {busy1, done1, ovf1, mode1, dig1}, {3'b000, 4'b1111, 16'h0000});
        prev_bcd  = 16'h0000;
        prev_mode = 4'b0001;
        prev_ovf  = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_no_activity", {busy, done, dig}, {2'b00, 16'h0000});

        // Directed table
        for (int i = 0; i < 10; i++) begin
            kick(tbl[i].b);
            expect_run(tbl[i].bcd, tbl[i].m, tbl[i].o, 1'b0, 1'b0, 14'd0);
        end

        // Start during conversion is ignored; restart in the done cycle is accepted
        kick(14'd1234);
        expect_run(16'h1234, 4'b1111, 1'b0, 1'b1, 1'b1, 14'd5678);
        expect_run(16'h5678, 4'b1111, 1'b0, 1'b0, 1'b0, 14'd0);

        // Reset in the middle of a conversion aborts it with no done pulse
        kick(14'd4321);
        expect_run(16'h4321, 4'b1111, 1'b0, 1'b0, 1'b0, 14'd0);
        kick(14'd8888);
        for (int n = 0; n < 7; n++) begin
            @(negedge clk);
            if (n == 0) start = 1'b0;
            if (n == 6) rst = 1'b0;
        end
        @(negedge clk);
        rst = 1'b1;
        chk("midrun_reset", {busy, done, ovf, mode, dig}, {1'b0, 1'b0, 1'b0, 4'b0001, 16'h0000});
        chk("midrun_reset_noblank", {busy1, ovf1, mode1, dig1}, {2'b00, 4'b1111, 16'h0000});
        prev_bcd  = 16'h0000;
        prev_mode = 4'b0001;
        prev_ovf  = 1'b0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            chk($sformatf("no_done_after_abort_%0d", n), {busy, done}, 2'b00);
        end
        kick(14'd55);
        expect_run(16'h0055, 4'b0011, 1'b0, 1'b0, 1'b0, 14'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
